// File: rtl/popcount_seq_ctrl.sv
// Sequential population counter: one 5-input bit counter is reused over a
// wide operand, one 5-bit chunk per clock, LSB chunk first, with the partial
// counts summed into a full-width result.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready is high only in IDLE, and
// out_valid is high only in DONE. While out_valid is high, out_count is held
// stable until the transfer occurs. Neither ready nor valid depends
// combinationally on the partner's signal.

module counter_5to3 (
  input  logic [4:0] bits_i,
  output logic [2:0] count_o
);

  // Number of set bits among five inputs (0..5).
  always_comb begin
    count_o = 3'(bits_i[0]) + 3'(bits_i[1]) + 3'(bits_i[2])
            + 3'(bits_i[3]) + 3'(bits_i[4]);
  end

endmodule

module popcount_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_count,
  output logic              busy
);

  localparam int NCHUNK = (DATA_W + 4) / 5;
  localparam int PAD_W  = NCHUNK * 5;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NCHUNK - 1);

  // The result must be able to hold DATA_W itself (an all-ones operand).
  generate
    if (OUT_W < $clog2(DATA_W + 1)) begin : g_out_w_check
      $error("popcount_seq_ctrl: OUT_W is too narrow for DATA_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [PAD_W-1:0]   shreg_q;
  logic [OUT_W-1:0]   acc_q;
  logic [CIDX_W-1:0]  idx_q;
  logic [2:0]         chunk_cnt;

  // The only bit counter; it always looks at the lowest chunk still pending.
  counter_5to3 u_counter (
    .bits_i  (shreg_q[4:0]),
    .count_o (chunk_cnt)
  );

  // Control FSM and datapath registers. clear outranks every transition,
  // including an input or output handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Zero padding above DATA_W keeps the top chunk's extra bits out
            // of the count.
            shreg_q <= PAD_W'(in_data);
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_q + OUT_W'(chunk_cnt);
          shreg_q <= shreg_q >> 5;
          idx_q   <= idx_q + CIDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // acc_q is left alone so out_count keeps its last value in IDLE.
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_count = acc_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Bench for popcount_seq_ctrl: directed scenarios plus randomized operands,
// checked against a transaction-level model (bit count, fixed latency,
// busy window) kept in a negedge monitor.

module tb_popcount_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 6;
  localparam int NCHUNK = (DATA_W + 4) / 5;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              clear = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_count;
  logic              busy;

  always #5 clk = ~clk;

  popcount_seq_ctrl #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int ones(input logic [DATA_W-1:0] w);
    int c = 0;
    for (int i = 0; i < DATA_W; i++) if (w[i]) c++;
    return c;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // An accepted operand is owed one result whose value is its bit count.
  // The result becomes visible NCHUNK+1 clocks after the accept edge (the
  // accept edge counts as the first). The block is busy from acceptance until
  // the result is taken, clear is applied, or reset is asserted.
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_q[$];
  int  cyc     = 0;
  int  acc_cyc = 0;
  bit  pending = 1'b0;
  bit  vld_pred;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_out_count", out_count, 0);
      exp_q.delete();
      pending = 1'b0;
    end else begin
      vld_pred = pending && ((cyc - acc_cyc) >= NCHUNK + 1);
      check_eq("in_ready", in_ready, !pending);
      check_eq("busy", busy, pending);
      check_eq("out_valid", out_valid, vld_pred);
      if (vld_pred && exp_q.size() > 0)
        check_eq("out_count", out_count, exp_q[0]);
      if (clear) begin
        exp_q.delete();
        pending = 1'b0;
      end else if (vld_pred && out_ready) begin
        got_q.push_back(out_count);
        void'(exp_q.pop_front());
        pending = 1'b0;
      end else if (!pending && in_valid) begin
        exp_q.push_back(OUT_W'(ones(in_data)));
        acc_cyc = cyc;
        pending = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer an operand until it is accepted; returns #1 after the accept edge.
  task automatic send(input logic [DATA_W-1:0] d, input bit keep_valid);
    int n = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("accept_seen", acc, 1);
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_data  = $urandom;
    end
  endtask

  // Wait for out_valid, stall the consumer for 'hold' cycles, then take it.
  task automatic wait_result(input int hold, output logic [OUT_W-1:0] got);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = out_valid;
      if (!seen) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check_eq("result_seen", seen, 1);
    got = out_count;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [OUT_W-1:0] g;
  logic [DATA_W-1:0] rd;
  int mode;

  initial begin
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);

    // All-zero operand: no bits, full latency window.
    send(32'h0000_0000, 1'b0);
    wait_result(0, g);
    check_eq("zero_count", g, 0);
    check_eq("zero_ready_after", in_ready, 1);

    // All-ones: top chunk holds only two data bits.
    send(32'hFFFF_FFFF, 1'b0);
    wait_result(0, g);
    check_eq("ones_count", g, 32);

    // Stalled consumer: result held for five cycles.
    send(32'h8000_0001, 1'b0);
    wait_result(5, g);
    check_eq("stall_count", g, 2);
    check_eq("stall_idle_after", busy, 0);

    // Back-to-back with in_valid held high.
    got_q.delete();
    out_ready = 1'b1;
    send(32'h0000_001F, 1'b1);
    in_data = 32'hA5A5_A5A5;
    send(32'hA5A5_A5A5, 1'b0);
    wait_result(0, g);
    check_eq("b2b_n_results", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("b2b_first", got_q[0], 5);
      check_eq("b2b_second", got_q[1], 16);
    end

    // clear on the third RUN cycle discards the operand.
    got_q.delete();
    send(32'hFFFF_FFFF, 1'b0);
    idle_cycles(2);
    clear = 1'b1;
    idle_cycles(1);
    clear = 1'b0;
    check_eq("clear_idle_ready", in_ready, 1);
    check_eq("clear_no_valid", out_valid, 0);
    send(32'h0000_000F, 1'b0);
    wait_result(0, g);
    check_eq("clear_next_count", g, 4);
    check_eq("clear_one_result", got_q.size(), 1);

    // Asynchronous reset between clock edges, mid-RUN.
    send(32'hDEAD_BEEF, 1'b0);
    idle_cycles(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready", in_ready, 1);
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_out_count", out_count, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_cycles(1);
    send(32'h1234_5678, 1'b0);
    wait_result(0, g);
    check_eq("post_rst_count", g, 13);

    // Randomized operands, stalls, stray out_ready and clear aborts.
    for (int it = 0; it < 40; it++) begin
      rd   = $urandom;
      mode = $urandom_range(0, 3);
      send(rd, 1'b0);
      if (mode == 0) begin
        idle_cycles($urandom_range(0, NCHUNK));
        clear = 1'b1;
        idle_cycles(1);
        clear = 1'b0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        idle_cycles(2);
        out_ready = 1'b0;
        wait_result($urandom_range(0, 4), g);
        check_eq("rand_count", g, ones(rd));
      end
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_seq_ctrl.md
Name: popcount_seq_ctrl

Overview:
Sequential Hamming-weight engine that time-multiplexes a single counter_5to3 instance over a wide input word, 5 bits per cycle. It accumulates the 3-bit partial counts into a full-width population count. A valid/ready handshake sits on both the input and result sides. It is the area-saving alternative to a full 5:3 compressor tree in the accumulator datapath.

Parameters:
DATA_W, 32, input word width; any value >= 1; the word is zero-padded on the MSB side to NCHUNK*5 bits
OUT_W, 6, result width; must be >= clog2(DATA_W+1); the elaboration check fails otherwise
(derived) NCHUNK = ceil(DATA_W/5); CIDX_W = clog2(NCHUNK), minimum 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept an operand
in_data  input  DATA_W  word to count
clear  input  1  synchronous abort; returns the block to IDLE
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_count  output  OUT_W  number of 1 bits in the accepted in_data
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift register=0, acc=0, chunk index=0. Outputs: in_ready=1, out_valid=0, out_count=0, busy=0.
- States: IDLE, RUN, DONE. The state is encoded in registers. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE: on a clock edge with in_valid&in_ready:
  - shreg <= zero-extended in_data
  - acc <= 0
  - idx <= 0
  - go to RUN
  Otherwise hold.
- RUN: one counter_5to3 is driven by shreg[4:0]. Each edge:
  - acc <= acc + zero-extended count (OUT_W-bit add; no overflow by construction)
  - shreg <= shreg >> 5
  - idx <= idx + 1
  On the edge where idx==NCHUNK-1, go to DONE. This gives exactly NCHUNK RUN cycles with LSB chunk first.
- DONE: out_count = acc, held stable while out_valid=1 and out_ready=0. When out_valid&out_ready on an edge, go to IDLE. acc is retained, so out_count keeps its last value while in IDLE; it is only meaningful while out_valid=1.
- Latency: out_valid rises NCHUNK+1 clocks after the accepting edge, e.g. 7+1 for DATA_W=32. Minimum initiation interval is NCHUNK+2 cycles, because in_ready is low during RUN and DONE.
- in_data is sampled only on the accepting edge. Later changes on in_data are ignored.
- clear:
  - Synchronous and takes priority over every transition.
  - From any state it forces IDLE with acc=0, idx=0, shreg=0.
  - A handshake presented in the same cycle is not accepted.
  - A result pending in DONE is discarded without an out handshake.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values. No result is produced.
- out_ready high in IDLE or RUN has no effect.
- Padding bits are always zero and never contribute to the count.
- Edge case NCHUNK==1 (DATA_W<=5): exactly one RUN cycle, then DONE.

Test Plan:
- DATA_W=32, in_data=0x00000000, out_ready=1 -> out_valid high exactly 8 clocks after accept edge, out_count=0; in_ready low for those 8 cycles, high the cycle after the result handshake.
- in_data=0xFFFFFFFF -> out_count=32 (6'b100000). Padding is confirmed not counted: the top chunk has only 2 data bits.
- in_data=0x80000001, out_ready held low 5 cycles after out_valid -> out_valid and out_count=2 stay stable for 5 cycles, then the handshake completes and the block returns to IDLE.
- Back-to-back operands 0x0000001F then 0xA5A5A5A5 with in_valid held high -> results 5 then 16 in order. The second accept occurs on the first cycle in_ready returns high.
- clear pulsed on the 3rd RUN cycle of 0xFFFFFFFF, then 0x0000000F issued -> no result for the first operand; the second yields out_count=4.
- rst_n pulsed low asynchronously mid-RUN (between clock edges) -> in_ready=1, out_valid=0, busy=0 immediately. After release, 0x12345678 yields out_count=13.
